fetch_unit: RTL and testbench

Parametrised instruction-fetch stage that replaces the single-register PC/ROM fetch. It holds the program counter, reads the combinational instruction memory, and queues fetched instructions with their PCs in a small FIFO. Decode consumes them through a valid/ready handshake, so decode stalls no longer drop or repeat instructions. It sits between the instruction ROM and the decode stage; taken branches from execute redirect the PC and flush the queue.

---
 rtl/fetch_unit_pkg.sv | 31 +++
 rtl/fetch_unit_if.sv | 51 +++++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : fetch_unit_pkg
//  Purpose : Shared instruction-set constants for the fetch stage: memory
//            geometry, default fetch-queue depth and the opcodes used to
//            build instruction words (including the NOP word presented on
//            an empty queue).
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package fetch_unit_pkg;

  // Instruction memory geometry (address bits, instruction word bits).
  localparam int LENGTH_INSTR_MEM = 10;
  localparam int WIDTH_INSTR_MEM  = 16;

  // Default number of entries in the fetch queue.
  localparam int FETCH_DEPTH      = 4;

  // Opcode occupies the top nibble of an instruction word.
  typedef enum logic [3:0] {
    OP_LDCA = 4'h1,
    OP_LDCB = 4'h2,
    OP_ADDA = 4'h3,
    OP_NOP  = 4'hF
  } opcode_e;

  localparam logic [WIDTH_INSTR_MEM-1:0] NOP = {OP_NOP, 12'h000};

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module  : fetch_unit_if
//  Purpose : Bundles the fetch stage's branch-redirect, instruction-memory
//            and decode handshake signals.
//  Ports   : master modport = fetch unit side, slave modport = environment
//            iBr_taken/iBr_dir : redirect request and target
//            oImem_addr/iImem_data : combinational instruction memory
//            oInstr/oInstr_pc/oNew_pc/oValid/iReady : decode handshake
//            oFetch_cnt/oFlush_cnt : present only with FETCH_PERF_EN
//  Config  : FETCH_PERF_EN adds the performance counter signals.
//  Rev     : 1.0  initial release
// ============================================================================
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = LENGTH_INSTR_MEM,
  parameter int INSTR_W = WIDTH_INSTR_MEM
);
  logic               iBr_taken;
  logic [ADDR_W-1:0]  iBr_dir;
  logic [ADDR_W-1:0]  oImem_addr;
  logic [INSTR_W-1:0] iImem_data;
  logic [INSTR_W-1:0] oInstr;
  logic [ADDR_W-1:0]  oInstr_pc;
  logic [ADDR_W-1:0]  oNew_pc;
  logic               oValid;
  logic               iReady;
`ifdef FETCH_PERF_EN
  logic [15:0]        oFetch_cnt;
  logic [15:0]        oFlush_cnt;
`endif

  modport master (
    input  iBr_taken, iBr_dir, iImem_data, iReady,
    output oImem_addr, oInstr, oInstr_pc, oNew_pc, oValid
`ifdef FETCH_PERF_EN
    , output oFetch_cnt, oFlush_cnt
`endif
  );

  modport slave (
    output iBr_taken, iBr_dir, iImem_data, iReady,
    input  oImem_addr, oInstr, oInstr_pc, oNew_pc, oValid
`ifdef FETCH_PERF_EN
    , input oFetch_cnt, oFlush_cnt
`endif
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : fetch_fifo
//  Purpose : Small circular queue holding fetched {instruction, pc} entries.
//            Head is read straight from the storage registers, so there is
//            no path from i_data to o_head within a cycle.
//  Ports   : clk, reset (async, active-low)
//            i_push, i_pop, i_flush : queue controls (flush wins)
//            i_data  : entry to write
//            o_head  : entry at the read pointer
//            o_count : number of valid entries (0..DEPTH)
//  Rev     : 1.0  initial release
// ============================================================================
module fetch_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic                     i_push,
  input  wire logic                     i_pop,
  input  wire logic                     i_flush,
  input  wire logic [WIDTH-1:0]         i_data,
  output logic      [WIDTH-1:0]         o_head,
  output logic      [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A flush cancels both operations of the same edge.
  assign w_do_push = i_push & ~i_flush;
  assign w_do_pop  = i_pop  & ~i_flush;

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers are exactly PTR_W bits wide, so DEPTH being a power of two
  // makes them wrap without an explicit compare.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module  : fetch_unit
//  Purpose : Instruction-fetch stage. Holds the PC, reads the external
//            combinational instruction ROM and queues {instruction, pc}
//            entries for decode behind a valid/ready handshake. A taken
//            branch redirects the PC and flushes the queue.
//  Ports   : clk            : clock, rising edge
//            reset          : asynchronous, active-low
//            bus (master)   : redirect, ROM and decode handshake signals
//  Config  : FETCH_PERF_EN adds 16-bit saturating push and flush counters
//            (oFetch_cnt, oFlush_cnt).
//  Rev     : 1.0  initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = LENGTH_INSTR_MEM,
  parameter int                INSTR_W  = WIDTH_INSTR_MEM,
  parameter int                DEPTH    = FETCH_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input wire logic     clk,
  input wire logic     reset,
  fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  w_count;
  logic [ENT_W-1:0]  w_head;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic [ADDR_W-1:0] w_instr_pc;

  assign w_valid = (w_count != '0);
  assign w_full  = (w_count == CNT_W'(DEPTH));
  assign w_pop   = w_valid & bus.iReady;
  // A pop frees a slot on the same edge, so a full queue can still accept.
  assign w_push  = ~bus.iBr_taken & (~w_full | w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (bus.iBr_taken) begin
      r_pc <= bus.iBr_dir;
    end else if (w_push) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.iBr_taken),
    .i_data  ({bus.iImem_data, r_pc}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign w_instr_pc     = w_valid ? w_head[ADDR_W-1:0] : '0;
  assign bus.oImem_addr = r_pc;
  assign bus.oValid     = w_valid;
  assign bus.oInstr     = w_valid ? w_head[ADDR_W +: INSTR_W] : INSTR_W'(NOP);
  assign bus.oInstr_pc  = w_instr_pc;
  assign bus.oNew_pc    = w_instr_pc + 1'b1;

`ifdef FETCH_PERF_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_flush_cnt;

  // Flushes are counted only when they actually discard queued work.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_push && (r_fetch_cnt != 16'hFFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 16'd1;
      end
      if (bus.iBr_taken && w_valid && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign bus.oFetch_cnt = r_fetch_cnt;
  assign bus.oFlush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_fetch_unit
//  Purpose : Self-checking bench for fetch_unit. A queue-based reference
//            model predicts what decode should see each cycle; a monitor
//            compares the DUT outputs against those predictions.
//  Config  : FETCH_PERF_EN also checks the performance counters.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int AW     = 10;
  localparam int IW     = 16;
  localparam int D      = 4;
  localparam int PC_MOD = 1 << AW;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  fetch_unit #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .DEPTH    (D),
    .RESET_PC (10'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External combinational instruction ROM.
  logic [IW-1:0] rom [PC_MOD];
  assign bus.iImem_data = rom[bus.oImem_addr];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } ent_t;

  typedef struct {
    bit          valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] addr;
  } snap_t;

  ent_t        mq[$];
  int unsigned mpc;
  int unsigned m_fetches;
  int unsigned m_flushes;
  snap_t       exp_q[$];
  bit          mon_en = 1'b0;

  function automatic void model_reset();
    mq.delete();
    mpc       = 0;
    m_fetches = 0;
    m_flushes = 0;
  endfunction

  function automatic snap_t model_snapshot();
    snap_t s;
    s.valid = (mq.size() != 0);
    s.instr = s.valid ? 32'(mq[0].instr) : 32'(NOP);
    s.pc    = s.valid ? 32'(mq[0].pc) : 32'd0;
    s.npc   = (s.pc + 1) % PC_MOD;
    s.addr  = mpc;
    return s;
  endfunction

  // One clock edge of the fetch stage described at queue level.
  function automatic void model_step(input bit br, input int unsigned dir, input bit rdy);
    ent_t e;
    if (br) begin
      if (mq.size() != 0) m_flushes++;
      mq.delete();
      mpc = dir % PC_MOD;
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (mq.size() < D) begin
        e.instr = rom[mpc];
        e.pc    = AW'(mpc);
        mq.push_back(e);
        mpc = (mpc + 1) % PC_MOD;
        m_fetches++;
      end
    end
  endfunction

  // Predict what the DUT shows this cycle, drive inputs, advance the model.
  task automatic cycle(input bit br, input int unsigned dir, input bit rdy);
    exp_q.push_back(model_snapshot());
    bus.iBr_taken = br;
    bus.iBr_dir   = AW'(dir);
    bus.iReady    = rdy;
    model_step(br, dir, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"},   32'(bus.oValid),     32'd0);
    check({tag, "_instr"},   32'(bus.oInstr),     32'(NOP));
    check({tag, "_pc"},      32'(bus.oInstr_pc),  32'd0);
    check({tag, "_new_pc"},  32'(bus.oNew_pc),    32'd1);
    check({tag, "_addr"},    32'(bus.oImem_addr), 32'd0);
  endtask

  // Called just after a rising edge; reset lands mid-cycle.
  task automatic async_reset(input string tag);
    mon_en = 1'b0;
    check({tag, "_pre_valid"}, 32'(bus.oValid), 32'(mq.size() != 0));
    #2;
    reset = 1'b0;
    #1;
    check_reset_values(tag);
    model_reset();
    bus.iBr_taken = 1'b0;
    bus.iReady    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        snap_t s;
        s = exp_q.pop_front();
        check("valid",     32'(bus.oValid),     32'(s.valid));
        check("imem_addr", 32'(bus.oImem_addr), s.addr);
        check("instr",     32'(bus.oInstr),     s.instr);
        check("instr_pc",  32'(bus.oInstr_pc),  s.pc);
        check("new_pc",    32'(bus.oNew_pc),    s.npc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit          br;
    bit          rdy;
    int unsigned sel;
    int unsigned dir;

    for (int a = 0; a < PC_MOD; a++) rom[a] = IW'($urandom);
    rom[0]  = {OP_LDCA, 12'h005};
    rom[1]  = {OP_LDCB, 12'h007};
    rom[2]  = NOP;
    rom[3]  = {OP_ADDA, 12'h000};
    rom[50] = NOP;

    bus.iBr_taken = 1'b0;
    bus.iBr_dir   = '0;
    bus.iReady    = 1'b0;

    #1 reset = 1'b0;
    #1 check_reset_values("por");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;

    // Streaming from reset, decode always ready.
    for (int i = 0; i < 8; i++) cycle(1'b0, 0, 1'b1);

    // Fill the queue, then reset asynchronously with it full.
    for (int i = 0; i < 6; i++) cycle(1'b0, 0, 1'b0);
    async_reset("rst_full");

    // Stall from reset, then drain in order.
    for (int i = 0; i < 10; i++) cycle(1'b0, 0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 0, 1'b1);

    // Branch with exactly three entries queued.
    async_reset("rst_b3");
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0);
    cycle(1'b1, 50, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 0, 1'b1);

    // Branch coinciding with a pop on a full queue.
    for (int i = 0; i < 6; i++) cycle(1'b0, 0, 1'b0);
    cycle(1'b1, 77, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 0, 1'b1);

    // PC wrap-around.
    cycle(1'b1, PC_MOD - 1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 0, 1'b1);

    // Randomized traffic with a stall-heavy window and one mid-run reset.
    for (int i = 0; i < 800; i++) begin
      br  = ($urandom_range(0, 11) == 0);
      sel = $urandom_range(0, 3);
      dir = (sel == 0) ? PC_MOD - 1 : (sel == 1) ? PC_MOD - 2 : $urandom_range(0, PC_MOD - 1);
      if (i >= 400 && i < 500) rdy = ($urandom_range(0, 3) == 0);
      else                     rdy = ($urandom_range(0, 3) != 0);
      if (i == 600) async_reset("rst_rand");
      cycle(br, dir, rdy);
    end

    mon_en = 1'b0;
    check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
`ifdef FETCH_PERF_EN
    check("fetch_cnt", 32'(bus.oFetch_cnt), (m_fetches > 32'hFFFF) ? 32'hFFFF : m_fetches);
    check("flush_cnt", 32'(bus.oFlush_cnt), (m_flushes > 32'hFFFF) ? 32'hFFFF : m_flushes);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
